// File: rtl/enemy_pkg.sv
// ---------------------------------------------------------------------------
// enemy_pkg
// Shared definitions for the enemy swarm controller and its channels:
//   - mode_e      : Y-motion mode encoding latched by a channel at spawn
//   - ch_state_e  : per-channel FSM state
//   - dir_e       : vertical direction used by the bounce mode
//   - DEF_*       : default screen geometry and timing constants
//   - wrap_spawn_y: folds the random seed into the playfield height
// ---------------------------------------------------------------------------
package enemy_pkg;

  typedef enum logic [1:0] {
    MODE_STRAIGHT = 2'b00,
    MODE_WRAP     = 2'b01,
    MODE_BOUNCE   = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FLY  = 2'b01,
    ST_HIT  = 2'b10
  } ch_state_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned RAND_W        = 10;
  localparam int unsigned DEF_N_ENEMY   = 4;
  localparam int unsigned DEF_W         = 12;
  localparam int unsigned DEF_TICK_DIV  = 1000000;
  localparam int unsigned DEF_X_SPAWN   = 1180;
  localparam int unsigned DEF_X_MIN     = 30;
  localparam int unsigned DEF_Y_MAX     = 700;
  localparam int unsigned DEF_Y_WRAP    = 20;
  localparam int unsigned DEF_DX        = 2;
  localparam int unsigned DEF_DY        = 5;
  localparam int unsigned DEF_HIT_TICKS = 8;

  // Seeds at or above the bottom edge are folded back to just below the
  // top margin so every spawn lands inside the visible band.
  function automatic int unsigned wrap_spawn_y(input logic [RAND_W-1:0] r,
                                               input int unsigned y_max,
                                               input int unsigned y_wrap);
    if (32'(r) < y_max) begin
      return 32'(r);
    end
    return 32'(r) - y_max + y_wrap;
  endfunction

endpackage

// File: rtl/enemy_channel.sv
// ---------------------------------------------------------------------------
// enemy_channel
// One enemy: IDLE -> FLY -> (IDLE | HIT -> IDLE) state machine plus its
// X/Y motion and hit-animation counter.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   tick            : movement tick (already suppressed while frozen)
//   spawn           : launch strobe from the arbiter (only honoured in IDLE)
//   spawn_y         : starting Y for a launch
//   spawn_mode      : Y-motion mode latched at launch
//   crash           : hit strobe, only honoured in FLY
//   x, y            : current position
//   active          : channel is flying
//   exploding       : channel is in hit animation
//   idle            : channel can accept a launch
// ---------------------------------------------------------------------------
module enemy_channel
  import enemy_pkg::*;
#(
  parameter int unsigned W         = DEF_W,
  parameter int unsigned X_SPAWN   = DEF_X_SPAWN,
  parameter int unsigned X_MIN     = DEF_X_MIN,
  parameter int unsigned Y_MAX     = DEF_Y_MAX,
  parameter int unsigned Y_WRAP    = DEF_Y_WRAP,
  parameter int unsigned DX        = DEF_DX,
  parameter int unsigned DY        = DEF_DY,
  parameter int unsigned HIT_TICKS = DEF_HIT_TICKS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         spawn,
  input  logic [W-1:0] spawn_y,
  input  mode_e        spawn_mode,
  input  logic         crash,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         active,
  output logic         exploding,
  output logic         idle
);

  localparam int unsigned HCW = (HIT_TICKS < 2) ? 1 : $clog2(HIT_TICKS);
  localparam logic [HCW-1:0] HIT_LAST = HCW'(HIT_TICKS - 1);

  // Sums and differences are formed one bit wider so the comparisons
  // against the screen edges never see a wrapped value.
  localparam logic [W:0]   X_MIN_E  = (W+1)'(X_MIN);
  localparam logic [W:0]   Y_MAX_E  = (W+1)'(Y_MAX);
  localparam logic [W:0]   DX_E     = (W+1)'(DX);
  localparam logic [W:0]   DY_E     = (W+1)'(DY);
  localparam logic [W:0]   Y_UP_LIM = (W+1)'(Y_WRAP + DY);
  localparam logic [W-1:0] X_HOME   = W'(X_SPAWN);
  localparam logic [W-1:0] Y_HOME   = W'(Y_WRAP);
  localparam logic [W-1:0] Y_BOTTOM = W'(Y_MAX - 1);
  localparam logic [W-1:0] DY_W     = W'(DY);

  ch_state_e      state_q,   state_d;
  dir_e           dir_q,     dir_d;
  mode_e          mode_q,    mode_d;
  logic [W-1:0]   x_q,       x_d;
  logic [W-1:0]   y_q,       y_d;
  logic [HCW-1:0] hit_cnt_q, hit_cnt_d;

  logic [W:0]   x_step;
  logic [W:0]   y_inc;
  logic [W-1:0] y_dec;

  // State register: reset parks the channel at the home position, heading
  // down in straight mode, regardless of anything else happening that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_DOWN;
      mode_q    <= MODE_STRAIGHT;
      x_q       <= X_HOME;
      y_q       <= Y_HOME;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      x_q       <= x_d;
      y_q       <= y_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  // Next-state and motion. A crash while flying beats a coincident tick,
  // so the position is frozen exactly where the hit happened. Leaving the
  // screen or finishing the hit animation both return to the home position.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    x_d       = x_q;
    y_d       = y_q;
    hit_cnt_d = hit_cnt_q;
    x_step    = {1'b0, x_q} - DX_E;
    y_inc     = {1'b0, y_q} + DY_E;
    y_dec     = y_q - DY_W;

    case (state_q)
      ST_IDLE: begin
        if (spawn) begin
          state_d = ST_FLY;
          x_d     = X_HOME;
          y_d     = spawn_y;
          mode_d  = spawn_mode;
          dir_d   = DIR_DOWN;
        end
      end

      ST_FLY: begin
        if (crash) begin
          state_d   = ST_HIT;
          hit_cnt_d = '0;
        end else if (tick) begin
          if (x_step <= X_MIN_E) begin
            state_d = ST_IDLE;
            x_d     = X_HOME;
            y_d     = Y_HOME;
            dir_d   = DIR_DOWN;
          end else begin
            x_d = x_step[W-1:0];
            case (mode_q)
              MODE_WRAP: begin
                y_d = (y_inc >= Y_MAX_E) ? Y_HOME : y_inc[W-1:0];
              end
              MODE_BOUNCE: begin
                if (dir_q == DIR_DOWN) begin
                  if (y_inc >= Y_MAX_E) begin
                    y_d   = Y_BOTTOM;
                    dir_d = DIR_UP;
                  end else begin
                    y_d = y_inc[W-1:0];
                  end
                end else begin
                  if ({1'b0, y_q} <= Y_UP_LIM) begin
                    y_d   = Y_HOME;
                    dir_d = DIR_DOWN;
                  end else begin
                    y_d = y_dec;
                  end
                end
              end
              default: begin
                y_d = y_q;
              end
            endcase
          end
        end
      end

      ST_HIT: begin
        if (tick) begin
          if (hit_cnt_q == HIT_LAST) begin
            state_d   = ST_IDLE;
            x_d       = X_HOME;
            y_d       = Y_HOME;
            dir_d     = DIR_DOWN;
            hit_cnt_d = '0;
          end else begin
            hit_cnt_d = hit_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are pure decodes of the registered state.
  always_comb begin
    x         = x_q;
    y         = y_q;
    active    = (state_q == ST_FLY);
    exploding = (state_q == ST_HIT);
    idle      = (state_q == ST_IDLE);
  end

endmodule

// File: rtl/enemy_swarm_ctrl.sv
// ---------------------------------------------------------------------------
// enemy_swarm_ctrl
// Movement tick divider, lowest-index spawn arbiter and N_ENEMY independent
// enemy channels.
// Ports:
//   clk, rst   : sole clock and synchronous active-high reset
//   freeze     : global pause; holds the tick divider (and thus all motion)
//   spawn_en   : allows a launch on the next tick
//   mode       : Y-motion mode given to the next launched enemy
//   randint    : random Y seed for launches
//   crash      : per-channel hit strobes
//   enemy_x/y  : packed positions, channel i at [i*W +: W]
//   active     : per-channel flying flag
//   exploding  : per-channel hit-animation flag
//   tick       : one-cycle movement tick pulse
// ---------------------------------------------------------------------------
module enemy_swarm_ctrl
  import enemy_pkg::*;
#(
  parameter int unsigned N_ENEMY   = DEF_N_ENEMY,
  parameter int unsigned W         = DEF_W,
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned X_SPAWN   = DEF_X_SPAWN,
  parameter int unsigned X_MIN     = DEF_X_MIN,
  parameter int unsigned Y_MAX     = DEF_Y_MAX,
  parameter int unsigned Y_WRAP    = DEF_Y_WRAP,
  parameter int unsigned DX        = DEF_DX,
  parameter int unsigned DY        = DEF_DY,
  parameter int unsigned HIT_TICKS = DEF_HIT_TICKS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 spawn_en,
  input  logic [1:0]           mode,
  input  logic [RAND_W-1:0]    randint,
  input  logic [N_ENEMY-1:0]   crash,
  output logic [N_ENEMY*W-1:0] enemy_x,
  output logic [N_ENEMY*W-1:0] enemy_y,
  output logic [N_ENEMY-1:0]   active,
  output logic [N_ENEMY-1:0]   exploding,
  output logic                 tick
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_ENEMY-1:0] idle;
  logic [N_ENEMY-1:0] spawn_vec;
  logic               spawn_taken;
  logic [W-1:0]       spawn_y;

  // Tick divider register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The divider simply stops while frozen; tick is masked too so nothing
  // moves and no hit animation advances during a pause.
  always_comb begin
    cnt_d = cnt_q;
    if (!freeze) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
    tick = !freeze && (cnt_q == CNT_LAST);
  end

  // Spawn arbiter: on a tick, hand the launch to the lowest-numbered channel
  // that is idle in its registered state. A channel that drops back to idle
  // on this same tick is still FLY/HIT here, so it waits one more tick.
  always_comb begin
    spawn_vec   = '0;
    spawn_taken = 1'b0;
    if (tick && spawn_en) begin
      for (int i = 0; i < int'(N_ENEMY); i++) begin
        if (idle[i] && !spawn_taken) begin
          spawn_vec[i] = 1'b1;
          spawn_taken  = 1'b1;
        end
      end
    end
  end

  assign spawn_y = W'(wrap_spawn_y(randint, Y_MAX, Y_WRAP));

  for (genvar g = 0; g < int'(N_ENEMY); g++) begin : g_ch
    enemy_channel #(
      .W         (W),
      .X_SPAWN   (X_SPAWN),
      .X_MIN     (X_MIN),
      .Y_MAX     (Y_MAX),
      .Y_WRAP    (Y_WRAP),
      .DX        (DX),
      .DY        (DY),
      .HIT_TICKS (HIT_TICKS)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick       (tick),
      .spawn      (spawn_vec[g]),
      .spawn_y    (spawn_y),
      .spawn_mode (mode_e'(mode)),
      .crash      (crash[g]),
      .x          (enemy_x[g*W +: W]),
      .y          (enemy_y[g*W +: W]),
      .active     (active[g]),
      .exploding  (exploding[g]),
      .idle       (idle[g])
    );
  end

endmodule

// File: tb/tb_enemy_swarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enemy_swarm_ctrl
// Directed bench for enemy_swarm_ctrl with TICK_DIV=4, N_ENEMY=4 and the
// default screen geometry. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_enemy_swarm_ctrl;

  localparam int N = 4;
  localparam int W = 12;

  logic           clk = 1'b0;
  logic           rst;
  logic           freeze;
  logic           spawn_en;
  logic [1:0]     mode;
  logic [9:0]     randint;
  logic [N-1:0]   crash;
  logic [N*W-1:0] enemy_x;
  logic [N*W-1:0] enemy_y;
  logic [N-1:0]   active;
  logic [N-1:0]   exploding;
  logic           tick;

  int total = 0;
  int bad   = 0;

  enemy_swarm_ctrl #(
    .N_ENEMY  (N),
    .W        (W),
    .TICK_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .freeze    (freeze),
    .spawn_en  (spawn_en),
    .mode      (mode),
    .randint   (randint),
    .crash     (crash),
    .enemy_x   (enemy_x),
    .enemy_y   (enemy_y),
    .active    (active),
    .exploding (exploding),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sp, input logic [1:0] md, input logic [9:0] ri,
                               input logic [N-1:0] cr, input logic fz);
    spawn_en = sp;
    mode     = md;
    randint  = ri;
    crash    = cr;
    freeze   = fz;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] xOf(input int i);
    return 32'(enemy_x[i*W +: W]);
  endfunction

  function automatic logic [31:0] yOf(input int i);
    return 32'(enemy_y[i*W +: W]);
  endfunction

  // Step until tick is seen high (bounded); returns the clocks waited.
  task automatic waitTickHigh(output int waited);
    waited = 0;
    while (tick !== 1'b1 && waited < 40) begin
      stepClk();
      waited++;
    end
    if (tick !== 1'b1) checkOutput("tick_timeout", 32'(tick), 32'd1);
  endtask

  // Run through the next tick edge so its effects are visible.
  task automatic runToTick();
    int w;
    waitTickHigh(w);
    stepClk();
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 10'd0, 4'b0000, 1'b0);
    stepClk();
    rst = 1'b0;
  endtask

  initial begin
    int w;
    int tickSeen;

    $display("[TB] start");
    rst = 1'b1;
    applyStimulus(1'b0, 2'b00, 10'd0, 4'b0000, 1'b0);
    stepClk();
    stepClk();
    checkOutput("rst_active", 32'(active), 0);
    checkOutput("rst_exploding", 32'(exploding), 0);
    checkOutput("rst_tick", 32'(tick), 0);
    checkOutput("rst_x3", xOf(3), 1180);
    checkOutput("rst_y3", yOf(3), 20);
    rst = 1'b0;

    // Wrap-mode spawn and first move
    applyStimulus(1'b1, 2'b01, 10'd350, 4'b0000, 1'b0);
    waitTickHigh(w);
    checkOutput("tick_period", 32'(w), 3);
    stepClk();
    checkOutput("tick_pulse_width", 32'(tick), 0);
    checkOutput("a_active", 32'(active), 4'b0001);
    checkOutput("a_x0_spawn", xOf(0), 1180);
    checkOutput("a_y0_spawn", yOf(0), 350);
    applyStimulus(1'b0, 2'b01, 10'd350, 4'b0000, 1'b0);
    runToTick();
    checkOutput("a_x0_move", xOf(0), 1178);
    checkOutput("a_y0_move", yOf(0), 355);
    checkOutput("a_active_one", 32'(active), 4'b0001);

    // Bounce off the bottom edge
    doReset();
    applyStimulus(1'b1, 2'b10, 10'd695, 4'b0000, 1'b0);
    runToTick();
    checkOutput("b_y0_spawn", yOf(0), 695);
    applyStimulus(1'b0, 2'b10, 10'd695, 4'b0000, 1'b0);
    runToTick();
    checkOutput("b_y0_bottom", yOf(0), 699);
    checkOutput("b_x0", xOf(0), 1178);
    runToTick();
    checkOutput("b_y0_up", yOf(0), 694);

    // Fill all four channels, fifth tick spawns nothing
    doReset();
    applyStimulus(1'b1, 2'b00, 10'd100, 4'b0000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      runToTick();
      checkOutput("c_active_fill", 32'(active), (32'd1 << k) - 32'd1);
    end
    runToTick();
    checkOutput("c_active_full", 32'(active), 4'b1111);
    checkOutput("c_x0", xOf(0), 1172);
    checkOutput("c_x3", xOf(3), 1178);
    checkOutput("c_y3", yOf(3), 100);

    // Crash on ch1 in the same cycle as a tick
    applyStimulus(1'b0, 2'b00, 10'd0, 4'b0000, 1'b0);
    waitTickHigh(w);
    applyStimulus(1'b0, 2'b00, 10'd0, 4'b0010, 1'b0);
    stepClk();
    applyStimulus(1'b0, 2'b00, 10'd0, 4'b0000, 1'b0);
    checkOutput("d_exploding", 32'(exploding), 4'b0010);
    checkOutput("d_active", 32'(active), 4'b1101);
    checkOutput("d_x1_held", xOf(1), 1174);
    checkOutput("d_y1_held", yOf(1), 100);
    checkOutput("d_x0", xOf(0), 1170);
    for (int k = 0; k < 3; k++) runToTick();
    checkOutput("d_x0_t9", xOf(0), 1164);
    checkOutput("d_exploding_t9", 32'(exploding), 4'b0010);

    // Freeze for 20 clocks; crash ch2 while frozen
    applyStimulus(1'b0, 2'b00, 10'd0, 4'b0000, 1'b1);
    tickSeen = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) applyStimulus(1'b0, 2'b00, 10'd0, 4'b0100, 1'b1);
      stepClk();
      if (i == 10) applyStimulus(1'b0, 2'b00, 10'd0, 4'b0000, 1'b1);
      if (tick === 1'b1) tickSeen++;
    end
    checkOutput("f_no_ticks", 32'(tickSeen), 0);
    checkOutput("f_x0_hold", xOf(0), 1164);
    checkOutput("f_x2_hold", xOf(2), 1168);
    checkOutput("f_exploding", 32'(exploding), 4'b0110);
    checkOutput("f_active", 32'(active), 4'b1001);
    applyStimulus(1'b0, 2'b00, 10'd0, 4'b0000, 1'b0);
    waitTickHigh(w);
    checkOutput("f_resume_period", 32'(w), 3);
    stepClk();
    checkOutput("f_x0_resume", xOf(0), 1162);
    for (int k = 0; k < 3; k++) runToTick();
    checkOutput("d_hit_7ticks", 32'(exploding), 4'b0110);
    runToTick();
    checkOutput("d_hit_done", 32'(exploding), 4'b0100);
    checkOutput("d_active_after", 32'(active), 4'b1001);
    checkOutput("d_x1_home", xOf(1), 1180);
    checkOutput("d_y1_home", yOf(1), 20);
    checkOutput("d_x0_t14", xOf(0), 1154);

    // Crash on an idle channel is ignored
    applyStimulus(1'b0, 2'b00, 10'd0, 4'b0010, 1'b0);
    stepClk();
    applyStimulus(1'b0, 2'b00, 10'd0, 4'b0000, 1'b0);
    checkOutput("idle_crash_exploding", 32'(exploding), 4'b0100);
    checkOutput("idle_crash_active", 32'(active), 4'b1001);

    // Reset in the middle of flight and hit animation
    rst = 1'b1;
    stepClk();
    checkOutput("midrst_exploding", 32'(exploding), 0);
    checkOutput("midrst_active", 32'(active), 0);
    checkOutput("midrst_x2", xOf(2), 1180);
    checkOutput("midrst_y2", yOf(2), 20);
    rst = 1'b0;

    // Folded spawn Y and exit at the left edge
    doReset();
    applyStimulus(1'b1, 2'b00, 10'd1000, 4'b0000, 1'b0);
    runToTick();
    checkOutput("e_y0_fold", yOf(0), 320);
    applyStimulus(1'b0, 2'b00, 10'd1000, 4'b0000, 1'b0);
    for (int k = 0; k < 574; k++) runToTick();
    checkOutput("e_x0_edge", xOf(0), 32);
    checkOutput("e_active_edge", 32'(active), 4'b0001);
    applyStimulus(1'b1, 2'b00, 10'd50, 4'b0000, 1'b0);
    runToTick();
    checkOutput("e_active_exit", 32'(active), 4'b0010);
    checkOutput("e_x1_spawn", xOf(1), 1180);
    checkOutput("e_y1_spawn", yOf(1), 50);
    runToTick();
    checkOutput("e_active_respawn", 32'(active), 4'b0011);
    checkOutput("e_x0_respawn", xOf(0), 1180);
    checkOutput("e_y0_respawn", yOf(0), 50);
    checkOutput("e_x1_move", xOf(1), 1178);

    // Wrap at the bottom edge, mode 11 behaves as straight
    doReset();
    applyStimulus(1'b1, 2'b01, 10'd690, 4'b0000, 1'b0);
    runToTick();
    checkOutput("g_y0_spawn", yOf(0), 690);
    applyStimulus(1'b1, 2'b11, 10'd200, 4'b0000, 1'b0);
    runToTick();
    checkOutput("g_y0_step", yOf(0), 695);
    checkOutput("g_y1_spawn", yOf(1), 200);
    applyStimulus(1'b0, 2'b11, 10'd200, 4'b0000, 1'b0);
    runToTick();
    checkOutput("g_y0_wrap", yOf(0), 20);
    checkOutput("g_x0", xOf(0), 1176);
    checkOutput("g_y1_hold", yOf(1), 200);
    checkOutput("g_x1", xOf(1), 1178);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enemy_swarm_ctrl.md
ENEMY_SWARM_CTRL -- requirements
Module: enemy_swarm_ctrl

Interface
REQ-001 SHALL have parameter N_ENEMY, default 4, number of independent enemy channels (1..16).
REQ-002 SHALL have parameter W, default 12, coordinate width in bits.
REQ-003 SHALL have parameter TICK_DIV, default 1000000, clocks per movement tick (>=2).
REQ-004 SHALL have parameters X_SPAWN=1180, X_MIN=30, Y_MAX=700, Y_WRAP=20, DX=2, DY=5, HIT_TICKS=8, all in pixels or ticks.
REQ-005 SHALL have port clk  input  1  system clock; sole clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port freeze  input  1  global pause (player crash); high holds the tick counter and all positions.
REQ-008 SHALL have port spawn_en  input  1  permits launching new enemies.
REQ-009 SHALL have port mode  input  2  Y-motion mode applied to the next spawned enemy.
REQ-010 SHALL have port randint  input  10  random Y seed for spawn.
REQ-011 SHALL have port crash  input  N_ENEMY  per-channel hit strobe, bit i for channel i.
REQ-012 SHALL have port enemy_x  output  N_ENEMY*W  packed X positions, channel i at bits [i*W +: W].
REQ-013 SHALL have port enemy_y  output  N_ENEMY*W  packed Y positions, same packing.
REQ-014 SHALL have port active  output  N_ENEMY  channel i is flying (drawable).
REQ-015 SHALL have port exploding  output  N_ENEMY  channel i is in hit animation.
REQ-016 SHALL have port tick  output  1  one-cycle pulse per movement tick.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 while freeze=0, hold while freeze=1, and assert tick for one cycle when count==TICK_DIV-1 (then wrap to 0).
REQ-018 Each channel SHALL run FSM IDLE -> FLY -> (IDLE | HIT -> IDLE); active=1 only in FLY, exploding=1 only in HIT.
REQ-019 On tick with spawn_en=1, exactly one IDLE channel (lowest index) SHALL enter FLY; none if all busy.
REQ-020 Spawn SHALL load x=X_SPAWN, y=randint if randint<Y_MAX else randint-Y_MAX+Y_WRAP, latch mode and set direction=down.
REQ-021 On tick in FLY, x SHALL become x-DX; if resulting x<=X_MIN the channel SHALL return to IDLE that tick.
REQ-022 Mode 00 (straight): y SHALL hold.
REQ-023 Mode 01 (wrap): y SHALL become y+DY, or Y_WRAP when y+DY>=Y_MAX.
REQ-024 Mode 10 (bounce): down adds DY until y+DY>=Y_MAX, then y=Y_MAX-1 and direction=up; up subtracts DY until y<=Y_WRAP+DY, then y=Y_WRAP and direction=down.
REQ-025 Mode 11 SHALL behave as mode 00.
REQ-026 crash[i]=1 in FLY SHALL enter HIT next clock regardless of tick or freeze, position frozen; crash in IDLE or HIT SHALL be ignored.
REQ-027 crash and tick in the same cycle: crash wins, no movement that cycle.
REQ-028 HIT SHALL last HIT_TICKS ticks (per-channel counter, paused by freeze), then IDLE with x=X_SPAWN, y=Y_WRAP.
REQ-029 A channel returning to IDLE on a tick SHALL not be eligible for spawn until the following tick.
REQ-030 All arithmetic SHALL be W-bit unsigned; no underflow below X_MIN given DX<X_MIN.

Reset
REQ-031 rst=1 SHALL, on the next clk edge: counter=0, tick=0, all channels IDLE, x=X_SPAWN, y=Y_WRAP, active=0, exploding=0, direction=down, mode latches=00.
REQ-032 rst SHALL take priority over freeze, crash and tick, including mid-flight and mid-HIT.

Structure
REQ-033 Shared package enemy_pkg SHALL hold the mode encoding (MODE_STRAIGHT, MODE_WRAP, MODE_BOUNCE), FSM state type, and default screen constants.
REQ-034 One sub-module enemy_channel SHALL implement a single channel's FSM and motion, instantiated N_ENEMY times via generate; tick divider and spawn arbiter stay in the top.

Verification (bench uses TICK_DIV=4, N_ENEMY=4)
REQ-035 rst then spawn_en=1, randint=350, mode=01 -> ch0 active after first tick, x=1180,y=350; next tick x=1178,y=355.
REQ-036 Mode 10, spawn y=695 -> next tick y=699 direction up; following tick y=694.
REQ-037 spawn_en=1 for 5 ticks -> channels 0..3 active in order, 5th tick spawns nothing.
REQ-038 crash[1] asserted same cycle as tick -> ch1 position unchanged, exploding[1]=1 for 8 ticks, then IDLE at (1180,20).
REQ-039 freeze=1 for 20 clocks mid-flight -> no tick pulses, positions/HIT counters hold; resume continues exact sequence.
REQ-040 randint=1000 -> spawn y=320; channel reaching x<=30 -> active drops that tick, respawn no earlier than next tick.
